// File: rtl/decode_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_queue
// Description : Circular instruction queue between fetch and the two decoder
//               slots; accepts up to 2/cycle and issues the oldest 1-2 in order.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_queue #(
    parameter int IQ_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic [1:0]                  fetch_valid_i,
    input  logic [1:0][31:0]            fetch_instr_i,
    input  logic [1:0][31:0]            fetch_pc_i,
    output logic                        fetch_ready_o,
    output logic [1:0]                  dec_valid_o,
    output logic [1:0][31:0]            dec_instr_o,
    output logic [1:0][31:0]            dec_pc_o,
    input  logic                        dec_ready_i,
    output logic [$clog2(IQ_DEPTH):0]   count_o
);

    localparam int c_ptr_w = $clog2(IQ_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_instr [IQ_DEPTH];
    logic [31:0]        r_pc    [IQ_DEPTH];

    logic [c_ptr_w-1:0] w_head_p1;
    logic [c_ptr_w-1:0] w_tail_p1;
    logic [c_ptr_w-1:0] w_slot1_idx;
    logic               w_enq_fire;
    logic               w_wr0;
    logic               w_wr1;
    logic [1:0]         w_enq_num;
    logic [1:0]         w_deq_num;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign w_head_p1 = r_head + 1'b1;
    assign w_tail_p1 = r_tail + 1'b1;

    // Ready looks only at registered occupancy, never at this cycle's dequeue.
    assign fetch_ready_o = (r_count <= c_cnt_w'(IQ_DEPTH - 2));
    assign count_o       = r_count;

    assign dec_valid_o[0] = (r_count != '0) & ~flush_i;
    assign dec_valid_o[1] = (r_count >= c_cnt_w'(2)) & ~flush_i;

    assign dec_instr_o[0] = r_instr[r_head];
    assign dec_instr_o[1] = r_instr[w_head_p1];
    assign dec_pc_o[0]    = r_pc[r_head];
    assign dec_pc_o[1]    = r_pc[w_head_p1];

    assign w_enq_fire = fetch_ready_o & (|fetch_valid_i) & ~flush_i;
    assign w_wr0      = w_enq_fire & fetch_valid_i[0];
    assign w_wr1      = w_enq_fire & fetch_valid_i[1];

    // Slot 1 lands right after slot 0 when both are valid, else at the tail.
    assign w_slot1_idx = fetch_valid_i[0] ? w_tail_p1 : r_tail;

    always_comb begin
        w_enq_num = 2'd0;
        if (w_enq_fire) begin
            w_enq_num = {1'b0, fetch_valid_i[0]} + {1'b0, fetch_valid_i[1]};
        end
    end

    always_comb begin
        w_deq_num = 2'd0;
        if (dec_ready_i) begin
            w_deq_num = {1'b0, dec_valid_o[0]} + {1'b0, dec_valid_o[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_ptr_w'(w_deq_num);
            r_tail  <= r_tail + c_ptr_w'(w_enq_num);
            r_count <= r_count + c_cnt_w'(w_enq_num) - c_cnt_w'(w_deq_num);
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_wr0) begin
            r_instr[r_tail] <= fetch_instr_i[0];
            r_pc[r_tail]    <= fetch_pc_i[0];
        end
        if (w_wr1) begin
            r_instr[w_slot1_idx] <= fetch_instr_i[1];
            r_pc[w_slot1_idx]    <= fetch_pc_i[1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_queue
// Description : Self-checking bench for decode_issue_queue (vector table plus
//               reference-queue scoreboard and directed corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_queue;

    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic [1:0]      fetch_valid_i;
    logic [1:0][31:0] fetch_instr_i;
    logic [1:0][31:0] fetch_pc_i;
    logic            fetch_ready_o;
    logic [1:0]      dec_valid_o;
    logic [1:0][31:0] dec_instr_o;
    logic [1:0][31:0] dec_pc_o;
    logic            dec_ready_i;
    logic [3:0]      count_o;

    always #5 clk = ~clk;

    decode_issue_queue #(.IQ_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef struct packed {
        logic [1:0] fv;
        logic       dr;
        logic       fl;
        logic [1:0] exp_dv;
        logic       exp_rdy;
        logic [3:0] exp_cnt;
    } vec_t;

    entry_t      sb[$];
    vec_t        vecs [12];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] next_instr = 32'h0;
    logic [1:0]  s_dv;
    logic        s_rdy;
    logic [3:0]  s_cnt;
    logic [31:0] s_pc0;
    logic [31:0] s_pc1;
    logic [31:0] s_instr0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // One clock: drive at posedge+1, check/sample at negedge, update the model.
    task automatic cycle(input logic [1:0] fv, input logic dr, input logic fl);
        logic [1:0] exp_dv;
        logic       exp_rdy;
        int         n;
        fetch_valid_i    = fv;
        fetch_instr_i[0] = next_instr;
        fetch_instr_i[1] = next_instr + 32'd1;
        fetch_pc_i[0]    = next_pc;
        fetch_pc_i[1]    = next_pc + 32'd4;
        dec_ready_i      = dr;
        flush_i          = fl;
        @(negedge clk);
        exp_dv  = fl ? 2'b00 : (sb.size() >= 2 ? 2'b11 : (sb.size() == 1 ? 2'b01 : 2'b00));
        exp_rdy = (sb.size() <= DEPTH - 2);
        s_dv     = dec_valid_o;
        s_rdy    = fetch_ready_o;
        s_cnt    = count_o;
        s_pc0    = dec_pc_o[0];
        s_pc1    = dec_pc_o[1];
        s_instr0 = dec_instr_o[0];
        chk("dec_valid", 32'(dec_valid_o), 32'(exp_dv));
        chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_rdy));
        chk("count", 32'(count_o), 32'(sb.size()));
        if (exp_dv[0] && dec_valid_o[0]) begin
            chk("slot0_instr", dec_instr_o[0], sb[0].instr);
            chk("slot0_pc", dec_pc_o[0], sb[0].pc);
        end
        if (exp_dv[1] && dec_valid_o[1]) begin
            chk("slot1_instr", dec_instr_o[1], sb[1].instr);
            chk("slot1_pc", dec_pc_o[1], sb[1].pc);
        end
        if (fl) begin
            sb.delete();
            next_pc    = next_pc + 32'h1000;
            next_instr = next_instr + 32'h100;
        end else begin
            if (dr) begin
                n = int'(exp_dv[0]) + int'(exp_dv[1]);
                repeat (n) void'(sb.pop_front());
            end
            if (exp_rdy && fv != 2'b00) begin
                if (fv[0]) sb.push_back('{instr: next_instr, pc: next_pc});
                if (fv[1]) sb.push_back('{instr: next_instr + 32'd1, pc: next_pc + 32'd4});
                n = int'(fv[0]) + int'(fv[1]);
                next_pc    = next_pc + 32'(4 * n);
                next_instr = next_instr + 32'(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] fv, input logic dr);
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        fetch_valid_i = fv;
        dec_ready_i   = dr;
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        fetch_valid_i = 2'b00;
        sb.delete();
        @(negedge clk);
        chk("reset_dec_valid", 32'(dec_valid_o), 32'h0);
        chk("reset_fetch_ready", 32'(fetch_ready_o), 32'h1);
        chk("reset_count", 32'(count_o), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] p;
        logic [1:0]  fv;
        logic [1:0]  last_fv;
        logic        held;
        logic        dr;
        logic        fl;

        fetch_instr_i = '0;
        fetch_pc_i    = '0;
        // Back-pressure fill: {fv, dr, fl, exp_dv, exp_rdy, exp_cnt} seen pre-edge
        vecs[0]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0};
        vecs[1]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 4'd2};
        vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 4'd4};
        vecs[3]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 4'd6};
        vecs[4]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 4'd8};
        vecs[5]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 4'd8};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 4'd8};
        vecs[7]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 4'd6};
        vecs[8]  = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 4'd6};
        vecs[9]  = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 4'd4};
        vecs[10] = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 4'd2};
        vecs[11] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 4'd0};

        do_reset(2'b00, 1'b0);

        // Single-fetch stream
        next_pc    = 32'h1C00_0000;
        next_instr = 32'h0000_1111;
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        chk("single_dv", 32'(s_dv), 32'h1);
        chk("single_instr", s_instr0, 32'h0000_1111);
        chk("single_pc", s_pc0, 32'h1C00_0000);
        cycle(2'b00, 1'b1, 1'b0);
        chk("single_drained", 32'(s_cnt), 32'h0);

        // Back-pressure fill from the vector table
        next_pc    = 32'h100;
        next_instr = 32'hA000_0000;
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].fv, vecs[i].dr, vecs[i].fl);
            chk($sformatf("vec%0d_dv", i), 32'(s_dv), 32'(vecs[i].exp_dv));
            chk($sformatf("vec%0d_rdy", i), 32'(s_rdy), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(vecs[i].exp_cnt));
            if (i == 6) begin
                chk("fill_first_pc0", s_pc0, 32'h100);
                chk("fill_first_pc1", s_pc1, 32'h104);
            end
        end

        // Wrap-around: walk head to DEPTH-1 with single dispatches
        do_reset(2'b00, 1'b0);
        next_pc    = 32'h2000;
        next_instr = 32'hB000_0000;
        repeat (7) cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        p = next_pc;
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        chk("wrap_dv", 32'(s_dv), 32'h3);
        chk("wrap_pc0", s_pc0, p);
        chk("wrap_pc1", s_pc1, p + 32'd4);
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        chk("wrap_next_pc0", s_pc0, p + 32'd8);
        chk("wrap_next_pc1", s_pc1, p + 32'd12);
        cycle(2'b00, 1'b1, 1'b0);

        // Flush mid-stream with count = 5 and a concurrent fetch pair
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b1);
        chk("flush_pre_cnt", 32'(s_cnt), 32'd5);
        chk("flush_dv", 32'(s_dv), 32'h0);
        p = next_pc;
        cycle(2'b11, 1'b1, 1'b0);
        chk("flush_post_cnt", 32'(s_cnt), 32'h0);
        chk("flush_post_dv", 32'(s_dv), 32'h0);
        cycle(2'b00, 1'b1, 1'b0);
        chk("flush_new_pc0", s_pc0, p);

        // Simultaneous enqueue and dequeue at count = 3
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        chk("simul_pre_cnt", 32'(s_cnt), 32'd3);
        cycle(2'b00, 1'b0, 1'b0);
        chk("simul_post_cnt", 32'(s_cnt), 32'd3);

        // Random valid/ready stress; fetch holds its pair while not ready
        held    = 1'b0;
        last_fv = 2'b00;
        for (int i = 0; i < 200; i++) begin
            if (held) begin
                fv = last_fv;
            end else begin
                case ($urandom_range(0, 2))
                    0:       fv = 2'b00;
                    1:       fv = 2'b01;
                    default: fv = 2'b11;
                endcase
            end
            dr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 31) == 0);
            cycle(fv, dr, fl);
            held    = (fv != 2'b00) && !s_rdy && !fl;
            last_fv = fv;
        end
        repeat (5) cycle(2'b00, 1'b1, 1'b0);
        chk("drain_cnt", 32'(count_o), 32'h0);

        // Reset wins over an in-flight handshake on a non-empty queue
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        do_reset(2'b11, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
